fetch_redirect_unit: RTL and testbench

FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

---
 rtl/fetch_redirect_unit_pkg.sv | 25 ++
 rtl/fetch_redirect_unit_pc_register.sv | 29 ++
 rtl/fetch_redirect_unit.sv | 134 +++++++++++++
 tb/tb_fetch_redirect_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset fetch address, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_redirect_unit_pkg;

    // Redirect FSM: RUN fetches sequentially, PEND holds a latched target
    // until instruction memory can accept it.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } fru_state_e;

    localparam logic [31:0] FRU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FRU_PC_STEP  = 32'd4;

    // Instruction fetches are word-aligned; low target bits are dropped.
    function automatic logic [31:0] fru_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic fru_is_misaligned(input logic [31:0] addr);
        return |addr[1:0];
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_pc_register.sv
// 32-bit program counter register with load enable.
// Latency: 1 cycle from load_en to q.
// Backpressure: none; holds its value while load_en is low.
module pc_register
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = FRU_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_en_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // Load a new fetch address when enabled, otherwise hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_VAL;
        end else if (load_en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC sequencing with branch/jump redirect, latching the target while imem is busy.
// Latency: redirect applied at the next edge, or at the edge where IMEM_BUSY drops.
// Backpressure: STALL/IMEM_BUSY hold PC; a busy redirect waits in PEND (flushing IF/ID).
// Optional macro REDIRECT_CNT_EN adds the REDIRECT_COUNT output.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FRU_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PC_MUX_CONTROL,
    input  logic [31:0] BRANCH_OR_JUMP_ADDR,
    input  logic        REG_FLUSH,
    input  logic        STALL,
    input  logic        IMEM_BUSY,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4,
    output logic        IMEM_READ,
    output logic        IF_ID_WRITE,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        REDIRECT_PENDING,
    output logic        MISALIGNED
`ifdef REDIRECT_CNT_EN
    ,
    output logic [31:0] REDIRECT_COUNT
`endif
);

    fru_state_e  state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        misaligned_q, misaligned_d;
    logic        pend_q;
    logic        pc_load;
    logic [31:0] pc_d;
    logic [31:0] pc_cur;
    logic [31:0] pc_plus_4;
    logic [31:0] redirect_tgt;

    assign pc_plus_4    = pc_cur + FRU_PC_STEP;
    assign redirect_tgt = fru_align(BRANCH_OR_JUMP_ADDR);

    // Next-state, latched target and PC load decision.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        pc_load      = 1'b0;
        pc_d         = pc_plus_4;
        misaligned_d = misaligned_q |
                       (PC_MUX_CONTROL & fru_is_misaligned(BRANCH_OR_JUMP_ADDR));
        case (state_q)
            ST_RUN: begin
                if (PC_MUX_CONTROL) begin
                    if (!IMEM_BUSY) begin
                        // Redirect wins over STALL: the stalled fetch is discarded.
                        pc_load = 1'b1;
                        pc_d    = redirect_tgt;
                    end else begin
                        target_d = redirect_tgt;
                        state_d  = ST_PEND;
                    end
                end else if (!STALL && !IMEM_BUSY) begin
                    pc_load = 1'b1;
                    pc_d    = pc_plus_4;
                end
            end
            ST_PEND: begin
                // A newer redirect replaces the latched one.
                if (PC_MUX_CONTROL) begin
                    target_d = redirect_tgt;
                end
                if (!IMEM_BUSY) begin
                    pc_load = 1'b1;
                    pc_d    = PC_MUX_CONTROL ? redirect_tgt : target_q;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Redirect FSM state, latched target and registered status outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_RUN;
            target_q     <= 32'h0;
            misaligned_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            misaligned_q <= misaligned_d;
            pend_q       <= (state_d == ST_PEND);
        end
    end

    pc_register #(
        .RESET_VAL (RESET_PC)
    ) u_pc_register (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .load_en_i (pc_load),
        .d_i       (pc_d),
        .q_o       (pc_cur)
    );

`ifdef REDIRECT_CNT_EN
    logic [31:0] redirect_cnt_q;

    // Count every redirect pulse; wraps naturally at 2^32.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            redirect_cnt_q <= 32'h0;
        end else if (PC_MUX_CONTROL) begin
            redirect_cnt_q <= redirect_cnt_q + 32'd1;
        end
    end

    assign REDIRECT_COUNT = redirect_cnt_q;
`endif

    assign PC               = pc_cur;
    assign PC_PLUS_4        = pc_plus_4;
    assign IMEM_READ        = !RESET;
    assign IF_ID_FLUSH      = PC_MUX_CONTROL | REG_FLUSH | (state_q == ST_PEND);
    assign ID_EX_FLUSH      = PC_MUX_CONTROL | REG_FLUSH;
    assign IF_ID_WRITE      = !RESET & !STALL & !IMEM_BUSY & !IF_ID_FLUSH;
    assign REDIRECT_PENDING = pend_q;
    assign MISALIGNED       = misaligned_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed table-driven bench for fetch_redirect_unit plus reset-in-PEND sequence.
// Latency: inputs driven 1ns after posedge, outputs sampled before the next edge.
// Backpressure: STALL/IMEM_BUSY driven directly from the vector table.
module tb_fetch_redirect_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PC_MUX_CONTROL;
    logic [31:0] BRANCH_OR_JUMP_ADDR;
    logic        REG_FLUSH;
    logic        STALL;
    logic        IMEM_BUSY;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_4;
    logic        IMEM_READ;
    logic        IF_ID_WRITE;
    logic        IF_ID_FLUSH;
    logic        ID_EX_FLUSH;
    logic        REDIRECT_PENDING;
    logic        MISALIGNED;
`ifdef REDIRECT_CNT_EN
    logic [31:0] REDIRECT_COUNT;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .PC_MUX_CONTROL      (PC_MUX_CONTROL),
        .BRANCH_OR_JUMP_ADDR (BRANCH_OR_JUMP_ADDR),
        .REG_FLUSH           (REG_FLUSH),
        .STALL               (STALL),
        .IMEM_BUSY           (IMEM_BUSY),
        .PC                  (PC),
        .PC_PLUS_4           (PC_PLUS_4),
        .IMEM_READ           (IMEM_READ),
        .IF_ID_WRITE         (IF_ID_WRITE),
        .IF_ID_FLUSH         (IF_ID_FLUSH),
        .ID_EX_FLUSH         (ID_EX_FLUSH),
        .REDIRECT_PENDING    (REDIRECT_PENDING),
        .MISALIGNED          (MISALIGNED)
`ifdef REDIRECT_CNT_EN
        ,
        .REDIRECT_COUNT      (REDIRECT_COUNT)
`endif
    );

    // One cycle of stimulus with the expected in-cycle outputs and PC after the edge.
    typedef struct {
        logic        stall;
        logic        busy;
        logic        pmc;
        logic        flush;
        logic [31:0] tgt;
        logic        e_ifid;
        logic        e_idex;
        logic        e_wr;
        logic        e_pend;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    localparam int NV = 26;
    vec_t vt[NV];

    function automatic vec_t mk(input logic stall, input logic busy, input logic pmc,
                                input logic flush, input logic [31:0] tgt,
                                input logic e_ifid, input logic e_idex, input logic e_wr,
                                input logic e_pend, input logic [31:0] e_pc,
                                input logic e_mis);
        vec_t r;
        r.stall = stall; r.busy = busy; r.pmc = pmc; r.flush = flush; r.tgt = tgt;
        r.e_ifid = e_ifid; r.e_idex = e_idex; r.e_wr = e_wr; r.e_pend = e_pend;
        r.e_pc = e_pc; r.e_mis = e_mis;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic set_in(input logic stall, input logic busy, input logic pmc,
                          input logic flush, input logic [31:0] tgt);
        STALL = stall; IMEM_BUSY = busy; PC_MUX_CONTROL = pmc;
        REG_FLUSH = flush; BRANCH_OR_JUMP_ADDR = tgt;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc;

        //          stall busy pmc flush  target        ifid idex wr pend  pc after    mis
        vt[0]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_0004, 0);
        vt[1]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_0008, 0);
        vt[2]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_000C, 0);
        vt[3]  = mk(1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_000C, 0);
        vt[4]  = mk(0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0000_000C, 0);
        vt[5]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_0010, 0);
        vt[6]  = mk(0, 0, 1, 0, 32'h1000,      1, 1, 0, 0, 32'h0000_1000, 0);
        vt[7]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_1004, 0);
        vt[8]  = mk(1, 0, 0, 1, 32'h0,         1, 1, 0, 0, 32'h0000_1004, 0);
        vt[9]  = mk(0, 1, 1, 0, 32'h2000,      1, 1, 0, 0, 32'h0000_1004, 0);
        vt[10] = mk(0, 1, 0, 0, 32'h0,         1, 0, 0, 1, 32'h0000_1004, 0);
        vt[11] = mk(0, 1, 0, 0, 32'h0,         1, 0, 0, 1, 32'h0000_1004, 0);
        vt[12] = mk(0, 0, 0, 0, 32'h0,         1, 0, 0, 1, 32'h0000_2000, 0);
        vt[13] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_2004, 0);
        vt[14] = mk(1, 0, 1, 0, 32'h2002,      1, 1, 0, 0, 32'h0000_2000, 1);
        vt[15] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_2004, 1);
        vt[16] = mk(0, 1, 1, 0, 32'h3000,      1, 1, 0, 0, 32'h0000_2004, 1);
        vt[17] = mk(0, 1, 1, 0, 32'h4000,      1, 1, 0, 1, 32'h0000_2004, 1);
        vt[18] = mk(0, 1, 0, 0, 32'h0,         1, 0, 0, 1, 32'h0000_2004, 1);
        vt[19] = mk(0, 0, 0, 0, 32'h0,         1, 0, 0, 1, 32'h0000_4000, 1);
        vt[20] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_4004, 1);
        vt[21] = mk(0, 1, 1, 0, 32'h5000,      1, 1, 0, 0, 32'h0000_4004, 1);
        vt[22] = mk(0, 0, 1, 0, 32'h6000,      1, 1, 0, 1, 32'h0000_6000, 1);
        vt[23] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_6004, 1);
        vt[24] = mk(0, 0, 1, 0, 32'hFFFF_FFFC, 1, 1, 0, 0, 32'hFFFF_FFFC, 1);
        vt[25] = mk(0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h0000_0000, 1);

        // Reset phase
        set_in(0, 0, 0, 0, 32'h0);
        RESET = 1'b1;
        #2;
        check("rst_pc", 0, PC, 32'h0);
        check("rst_imem_read", 0, {31'h0, IMEM_READ}, 32'h0);
        check("rst_if_id_write", 0, {31'h0, IF_ID_WRITE}, 32'h0);
        check("rst_pending", 0, {31'h0, REDIRECT_PENDING}, 32'h0);
        check("rst_misaligned", 0, {31'h0, MISALIGNED}, 32'h0);
        tick();
        tick();
        RESET = 1'b0;
        #1;

        exp_pc = 32'h0;
        for (int i = 0; i < NV; i++) begin
            set_in(vt[i].stall, vt[i].busy, vt[i].pmc, vt[i].flush, vt[i].tgt);
            #1;
            check("pc_before", i, PC, exp_pc);
            check("pc_plus_4", i, PC_PLUS_4, exp_pc + 32'd4);
            check("imem_read", i, {31'h0, IMEM_READ}, 32'h1);
            check("if_id_flush", i, {31'h0, IF_ID_FLUSH}, {31'h0, vt[i].e_ifid});
            check("id_ex_flush", i, {31'h0, ID_EX_FLUSH}, {31'h0, vt[i].e_idex});
            check("if_id_write", i, {31'h0, IF_ID_WRITE}, {31'h0, vt[i].e_wr});
            check("pending", i, {31'h0, REDIRECT_PENDING}, {31'h0, vt[i].e_pend});
            @(posedge CLK);
            #1;
            check("pc_after", i, PC, vt[i].e_pc);
            check("misaligned", i, {31'h0, MISALIGNED}, {31'h0, vt[i].e_mis});
            exp_pc = vt[i].e_pc;
        end

`ifdef REDIRECT_CNT_EN
        // Redirect pulses in the table: rows 6,9,14,16,17,21,22,24.
        check("redirect_count", 0, REDIRECT_COUNT, 32'd8);
`endif

        // Reset while PEND holds a twice-overwritten redirect.
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        check("seq_pc_start", 0, PC, 32'h4);
        set_in(0, 1, 1, 0, 32'h3000);
        tick();
        check("seq_pend1", 0, {31'h0, REDIRECT_PENDING}, 32'h1);
        set_in(0, 1, 1, 0, 32'h3400);
        tick();
        check("seq_pend2", 0, {31'h0, REDIRECT_PENDING}, 32'h1);
        check("seq_pc_hold", 0, PC, 32'h4);
        set_in(0, 0, 0, 0, 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        check("seq_rst_pc", 0, PC, 32'h0);
        check("seq_rst_pending", 0, {31'h0, REDIRECT_PENDING}, 32'h0);
        check("seq_rst_misaligned", 0, {31'h0, MISALIGNED}, 32'h0);
        check("seq_rst_imem_read", 0, {31'h0, IMEM_READ}, 32'h0);
        check("seq_rst_if_id_flush", 0, {31'h0, IF_ID_FLUSH}, 32'h0);
`ifdef REDIRECT_CNT_EN
        check("seq_rst_count", 0, REDIRECT_COUNT, 32'h0);
`endif
        tick();
        RESET = 1'b0;
        #1;
        tick();
        // Pending target 0x3400 must have been discarded.
        check("seq_after_rst_pc", 0, PC, 32'h4);
        check("seq_after_rst_pending", 0, {31'h0, REDIRECT_PENDING}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
